ahb_arbiter_param: RTL and testbench
====================================

AHB_ARBITER_PARAM -- requirements
Module: ahb_arbiter_param

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 16, the number of bus masters; legal range 2..16, and any other value SHALL cause an elaboration error.
REQ-002 The block SHALL have parameter ARB_MODE, default 1, the arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-003 The block SHALL have parameter DEFAULT_MASTER, default 0, the index granted when no eligible request exists; legal range 0..NUM_MASTERS-1.
REQ-004 The block SHALL have derived localparam MW = max(1, clog2(NUM_MASTERS)), the width of the master index.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port HCLK, input, 1 bit: the clock; all state updates on its rising edge.
REQ-007 Port HRESET, input, 1 bit: synchronous active-high reset.
REQ-008 Port HBUSREQx, input, NUM_MASTERS bits: bus request, one bit per master.
REQ-009 Port HLOCKx, input, NUM_MASTERS bits: locked-transfer request, one bit per master.
REQ-010 Port HSPLIT, input, NUM_MASTERS bits: split-resume, one bit per master.
REQ-011 Port HREADY, input, 1 bit: current transfer complete.
REQ-012 Port HRESP, input, 2 bits: slave response; 2'b11 = SPLIT.
REQ-013 Port HGRANTx, output, NUM_MASTERS bits: registered one-hot grant.
REQ-014 Port HMASTER, output, MW bits: index of the master owning the address phase.
REQ-015 Port HMASTLOCK, output, 1 bit: the current address phase is locked.

Function
REQ-016 HGRANTx SHALL be exactly one-hot in every cycle, including reset.
REQ-017 eligible = HBUSREQx & ~split_mask, where split_mask is an internal NUM_MASTERS-bit register.
REQ-018 Rearbitration SHALL occur only at a rising edge with HREADY=1; with HREADY=0, HGRANTx, HMASTER, HMASTLOCK and the round-robin pointer SHALL hold.
REQ-019 Lock hold: if the granted master g has HLOCKx[g]=1, HBUSREQx[g]=1 and split_mask[g]=0, HGRANTx SHALL remain on g at the arbitration edge.
REQ-020 ARB_MODE=0: the lowest-index eligible master SHALL win.
REQ-021 ARB_MODE=1: the first eligible master searching from (ptr+1) mod NUM_MASTERS upward with wrap SHALL win; ptr SHALL load the winner index whenever a requesting master wins.
REQ-022 With eligible == 0 and no lock hold, the grant SHALL go to DEFAULT_MASTER; ptr SHALL be unchanged.
REQ-023 At each edge with HREADY=1, the block SHALL load HMASTER with the index of the pre-edge HGRANTx and HMASTLOCK with the pre-edge HLOCKx at that index, one cycle after the grant.
REQ-024 Split set: an edge with HREADY=0 and HRESP=2'b11 SHALL set split_mask[HMASTER], unless HMASTER == DEFAULT_MASTER, whose bit is never set.
REQ-025 Split clear: HSPLIT[i]=1 at an edge SHALL clear split_mask[i]; if set and clear hit the same bit in one edge, set SHALL win.
REQ-026 A master whose split_mask bit is set SHALL NOT be granted, and any lock hold on it SHALL be released at the next arbitration.
REQ-027 HLOCKx and HSPLIT bits of masters that are not requesting or not granted SHALL have no effect apart from REQ-025.

Reset
REQ-028 When HRESET=1 at an edge, the block SHALL load HGRANTx = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, split_mask = 0 and ptr = DEFAULT_MASTER, regardless of HREADY or a lock in progress.
REQ-029 Reset SHALL take priority over every other update in the same edge; outputs are valid from the first edge after HRESET falls.

Verification
REQ-030 Defaults, masters 2 and 5 requesting continuously, HREADY=1 -> grants alternate 2, 5, 2, 5; HMASTER follows one cycle later.
REQ-031 ARB_MODE=0, masters 2 and 5 requesting -> HGRANTx stays 16'h0004 indefinitely.
REQ-032 Master 3 granted with HLOCKx[3]=1, master 1 requesting, then HREADY=0 for 3 cycles -> grant and HMASTER hold; after HLOCKx[3] drops with HREADY=1 -> grant moves to 1; HMASTLOCK=1 only for master 3's address phases.
REQ-033 HMASTER=4, HRESP=2'b11 with HREADY=0 -> split_mask[4]=1 and master 4 is not granted although requesting; HSPLIT[4] pulse -> master 4 is granted at a later HREADY arbitration edge.
REQ-034 No requests -> HGRANTx = one-hot(DEFAULT_MASTER); HRESET asserted mid-lock -> all outputs at reset values at the next edge.

Source files
------------

// File: rtl/ahb_arbiter_param_if.sv
// Arbitration bus bundle: master requests, lock, split-resume and slave status in; grant and owner out.
// The arbiter attaches through the slave modport; the request side uses the master modport.
interface ahb_arbiter_param_if #(
    parameter int NUM_MASTERS = 16
);
    localparam int MW = ($clog2(NUM_MASTERS) < 1) ? 1 : $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] HBUSREQx;
    logic [NUM_MASTERS-1:0] HLOCKx;
    logic [NUM_MASTERS-1:0] HSPLIT;
    logic                   HREADY;
    logic [1:0]             HRESP;
    logic [NUM_MASTERS-1:0] HGRANTx;
    logic [MW-1:0]          HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQx, HLOCKx, HSPLIT, HREADY, HRESP,
        input  HGRANTx, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQx, HLOCKx, HSPLIT, HREADY, HRESP,
        output HGRANTx, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter_param.sv
// AHB bus arbiter: fixed-priority or round-robin grant with lock hold and split masking.
// Grant registered, rearbitrates only on HREADY edges; HMASTER/HMASTLOCK follow the grant by one cycle.
module ahb_arbiter_param #(
    parameter int NUM_MASTERS    = 16,
    parameter int ARB_MODE       = 1,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahb_arbiter_param_if.slave  bus
);
    localparam int MW = ($clog2(NUM_MASTERS) < 1) ? 1 : $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE     = NUM_MASTERS'(1);
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num
        $error("ahb_arbiter_param: NUM_MASTERS must be in 2..16");
    end
    if (ARB_MODE != 0 && ARB_MODE != 1) begin : g_bad_mode
        $error("ahb_arbiter_param: ARB_MODE must be 0 or 1");
    end
    if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_def
        $error("ahb_arbiter_param: DEFAULT_MASTER out of range");
    end

    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] r_split;
    logic [MW-1:0]          r_master;
    logic [MW-1:0]          r_ptr;
    logic                   r_mastlock;

    logic [NUM_MASTERS-1:0] w_eligible;
    logic [NUM_MASTERS-1:0] w_split_set;
    logic [MW-1:0]          w_gidx;
    logic [MW-1:0]          w_fp_idx;
    logic [MW-1:0]          w_rr_idx;
    logic [MW-1:0]          w_rr_cand;
    logic [MW-1:0]          w_win_idx;
    logic                   w_lock_hold;

    assign w_eligible  = bus.HBUSREQx & ~r_split;
    assign w_lock_hold = bus.HLOCKx[w_gidx] & bus.HBUSREQx[w_gidx] & ~r_split[w_gidx];
    // The default master is never split, so the bus always has somewhere safe to park.
    assign w_split_set = (!bus.HREADY && bus.HRESP == 2'b11 && r_master != DEF_IDX)
                         ? (ONE << r_master) : '0;
    assign w_win_idx   = (ARB_MODE == 0) ? w_fp_idx : w_rr_idx;

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) w_gidx = MW'(i);
        end
    end

    always_comb begin
        w_fp_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_eligible[i]) w_fp_idx = MW'(i);
        end
    end

    // Scan farthest-first so the nearest eligible master after ptr is the last write.
    always_comb begin
        w_rr_idx  = '0;
        w_rr_cand = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_rr_cand = MW'((int'(r_ptr) + k) % NUM_MASTERS);
            if (w_eligible[w_rr_cand]) w_rr_idx = w_rr_cand;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_grant    <= ONE << DEFAULT_MASTER;
            r_master   <= DEF_IDX;
            r_mastlock <= 1'b0;
            r_split    <= '0;
            r_ptr      <= DEF_IDX;
        end else begin
            r_split <= (r_split & ~bus.HSPLIT) | w_split_set;
            if (bus.HREADY) begin
                r_master   <= w_gidx;
                r_mastlock <= bus.HLOCKx[w_gidx];
                if (w_lock_hold) begin
                    r_ptr <= w_gidx;
                end else if (|w_eligible) begin
                    r_grant <= ONE << w_win_idx;
                    r_ptr   <= w_win_idx;
                end else begin
                    r_grant <= ONE << DEFAULT_MASTER;
                end
            end
        end
    end

    assign bus.HGRANTx   = r_grant;
    assign bus.HMASTER   = r_master;
    assign bus.HMASTLOCK = r_mastlock;
endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Three arbiter configurations share one randomized/directed stimulus stream;
// a reference model queues expected outputs per edge and a negedge monitor checks them.
module tb_ahb_arbiter_param;
    typedef struct {
        logic [15:0] grant;
        logic [15:0] master;
        logic        lock;
    } exp_t;

    logic        HCLK;
    logic        rst;
    logic [15:0] req, lck, hsp;
    logic        rdy;
    logic [1:0]  rsp;

    int n_total = 0;
    int n_bad   = 0;

    // d0: 16 masters round-robin default 0; d1: 16 masters fixed priority; d2: 6 masters round-robin default 3
    int cfg_n[3]    = '{16, 16, 6};
    int cfg_mode[3] = '{1, 0, 1};
    int cfg_def[3]  = '{0, 0, 3};

    int       m_g[3], m_p[3], m_m[3];
    bit       m_ml[3];
    bit [15:0] m_s[3];

    exp_t q0[$], q1[$], q2[$];

    ahb_arbiter_param_if #(.NUM_MASTERS(16)) if0 ();
    ahb_arbiter_param_if #(.NUM_MASTERS(16)) if1 ();
    ahb_arbiter_param_if #(.NUM_MASTERS(6))  if2 ();

    assign if0.HBUSREQx = req;       assign if1.HBUSREQx = req;       assign if2.HBUSREQx = req[5:0];
    assign if0.HLOCKx   = lck;       assign if1.HLOCKx   = lck;       assign if2.HLOCKx   = lck[5:0];
    assign if0.HSPLIT   = hsp;       assign if1.HSPLIT   = hsp;       assign if2.HSPLIT   = hsp[5:0];
    assign if0.HREADY   = rdy;       assign if1.HREADY   = rdy;       assign if2.HREADY   = rdy;
    assign if0.HRESP    = rsp;       assign if1.HRESP    = rsp;       assign if2.HRESP    = rsp;

    ahb_arbiter_param #(.NUM_MASTERS(16), .ARB_MODE(1), .DEFAULT_MASTER(0))
        u_dut0 (.HCLK(HCLK), .HRESET(rst), .bus(if0));
    ahb_arbiter_param #(.NUM_MASTERS(16), .ARB_MODE(0), .DEFAULT_MASTER(0))
        u_dut1 (.HCLK(HCLK), .HRESET(rst), .bus(if1));
    ahb_arbiter_param #(.NUM_MASTERS(6), .ARB_MODE(1), .DEFAULT_MASTER(3))
        u_dut2 (.HCLK(HCLK), .HRESET(rst), .bus(if2));

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Reference model: one arbitration edge, written from the bus rules.
    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int n, g, p, m;
            bit ml;
            bit [15:0] msk, r, l, s, ns, elig;
            exp_t e;
            n   = cfg_n[d];
            msk = (n == 16) ? 16'hFFFF : 16'((1 << n) - 1);
            r = req & msk; l = lck & msk; s = hsp & msk;
            g = m_g[d]; p = m_p[d]; m = m_m[d]; ml = m_ml[d];
            if (rst) begin
                g = cfg_def[d]; p = cfg_def[d]; m = cfg_def[d]; ml = 1'b0; ns = '0;
            end else begin
                ns = m_s[d] & ~s;
                if (!rdy && rsp == 2'b11 && m_m[d] != cfg_def[d]) ns[m_m[d]] = 1'b1;
                if (rdy) begin
                    m  = m_g[d];
                    ml = l[m_g[d]];
                    elig = r & ~m_s[d];
                    if (l[m_g[d]] && r[m_g[d]] && !m_s[d][m_g[d]]) begin
                        p = m_g[d];
                    end else if (elig != 0) begin
                        if (cfg_mode[d] == 0) begin
                            for (int k = n - 1; k >= 0; k--) if (elig[k]) g = k;
                        end else begin
                            for (int k = n; k >= 1; k--) if (elig[(m_p[d] + k) % n]) g = (m_p[d] + k) % n;
                        end
                        p = g;
                    end else begin
                        g = cfg_def[d];
                    end
                end
            end
            m_g[d] = g; m_p[d] = p; m_m[d] = m; m_ml[d] = ml; m_s[d] = ns;
            e.grant = 16'(1) << g; e.master = 16'(m); e.lock = ml;
            case (d)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic cyc(input logic r_i, input logic [15:0] req_i, input logic [15:0] lck_i,
                       input logic [15:0] hsp_i, input logic rdy_i, input logic [1:0] rsp_i);
        @(negedge HCLK);
        rst = r_i; req = req_i; lck = lck_i; hsp = hsp_i; rdy = rdy_i; rsp = rsp_i;
        @(posedge HCLK);
        model_step();
    endtask

    task automatic check(input int d, input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        n_total++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL dut%0d %s at %0t: got %h expected %h", d, nm, $time, act, exp_v);
        end
    endtask

    always @(negedge HCLK) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(0, "grant",    if0.HGRANTx, e.grant);
            check(0, "hmaster",  16'(if0.HMASTER), e.master);
            check(0, "mastlock", 16'(if0.HMASTLOCK), 16'(e.lock));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(1, "grant",    if1.HGRANTx, e.grant);
            check(1, "hmaster",  16'(if1.HMASTER), e.master);
            check(1, "mastlock", 16'(if1.HMASTLOCK), 16'(e.lock));
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check(2, "grant",    16'(if2.HGRANTx), e.grant);
            check(2, "hmaster",  16'(if2.HMASTER), e.master);
            check(2, "mastlock", 16'(if2.HMASTLOCK), 16'(e.lock));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r16, l16, h16;
        rst = 1'b1; req = '0; lck = '0; hsp = '0; rdy = 1'b1; rsp = 2'b00;
        repeat (3) cyc(1, 16'h0000, 16'h0000, 16'h0000, 1, 2'b00);
        // masters 2 and 5 requesting continuously
        repeat (8) cyc(0, 16'h0024, 16'h0000, 16'h0000, 1, 2'b00);
        // idle bus parks on the default master
        repeat (3) cyc(0, 16'h0000, 16'h0000, 16'h0000, 1, 2'b00);
        // locked master 3, competitor 1, then a stalled transfer and lock release
        repeat (3) cyc(0, 16'h0008, 16'h0008, 16'h0000, 1, 2'b00);
        repeat (2) cyc(0, 16'h000A, 16'h0008, 16'h0000, 1, 2'b00);
        repeat (3) cyc(0, 16'h000A, 16'h0008, 16'h0000, 0, 2'b00);
        repeat (3) cyc(0, 16'h000A, 16'h0000, 16'h0000, 1, 2'b00);
        // split of master 4, masking, then resume
        repeat (3) cyc(0, 16'h0010, 16'h0000, 16'h0000, 1, 2'b00);
        cyc(0, 16'h0010, 16'h0000, 16'h0000, 0, 2'b11);
        repeat (4) cyc(0, 16'h0050, 16'h0000, 16'h0000, 1, 2'b00);
        cyc(0, 16'h0050, 16'h0000, 16'h0010, 1, 2'b00);
        repeat (4) cyc(0, 16'h0050, 16'h0000, 16'h0000, 1, 2'b00);
        // reset arriving in the middle of a locked sequence
        repeat (3) cyc(0, 16'h0008, 16'h0008, 16'h0000, 1, 2'b00);
        cyc(0, 16'h0008, 16'h0008, 16'h0000, 0, 2'b00);
        cyc(1, 16'h0008, 16'h0008, 16'h0000, 0, 2'b00);
        repeat (2) cyc(0, 16'h0000, 16'h0000, 16'h0000, 1, 2'b00);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r16 = 16'($urandom) & 16'($urandom);
            l16 = 16'($urandom) & 16'($urandom);
            h16 = ($urandom_range(0, 3) == 0) ? (16'(1) << $urandom_range(0, 15)) : 16'h0000;
            cyc(($urandom_range(0, 199) == 0), r16, l16, h16, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
        end
        @(negedge HCLK);
        @(negedge HCLK);
        n_total++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q0.size() + q1.size() + q2.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
